// File: rtl/sha2_pkg.sv
// Shared SHA-2 constants, state type and round helper functions.
package sha2_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, ROUND, FINAL} state_t;

  // Word 7 is a/H0 so a packed hash_t lines up with the {H0..H7} digest layout.
  typedef logic [7:0][31:0] hash_t;

  localparam hash_t IV256 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                             32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam hash_t IV224 = {32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                             32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha2_round.sv
// One combinational SHA-2 compression round: {a..h}, K, W -> next {a..h}.
module sha2_round
  import sha2_pkg::*;
(
  input  hash_t       cur,
  input  logic [31:0] k,
  input  logic [31:0] w,
  output hash_t       nxt
);

  logic [31:0] t1, t2;

  // a=7 b=6 c=5 d=4 e=3 f=2 g=1 h=0
  assign t1  = cur[0] + big_sigma1(cur[3]) + ch(cur[3], cur[2], cur[1]) + k + w;
  assign t2  = big_sigma0(cur[7]) + maj(cur[7], cur[6], cur[5]);
  assign nxt = {t1 + t2, cur[7], cur[6], cur[5], cur[4] + t1, cur[3], cur[2], cur[1]};

endmodule

// File: rtl/sha2_round_engine.sv
// SHA-224/256 compression engine, UNROLL rounds per beat.
// Define SHA2_SCHEDULE_EN to take the whole block on blk_i and expand W internally.
module sha2_round_engine
  import sha2_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  abort_i,
  input  logic                  blk_valid_i,
  output logic                  blk_ready_o,
  input  logic                  init_i,
  input  logic                  mode_i,
`ifdef SHA2_SCHEDULE_EN
  input  logic [511:0]          blk_i,
`else
  input  logic                  w_valid_i,
  output logic                  w_ready_o,
  input  logic [32*UNROLL-1:0]  w_i,
`endif
  output logic                  done_o,
  output logic [255:0]          digest_o,
  output logic                  busy_o
);

  localparam int LAST = 64 - UNROLL;

  state_t state, state_nxt;
  hash_t  h_q, wk, h_sum;
  logic [255:0] digest_q;
  logic   mode_q, done_q, accept, beat;
  logic [5:0] rnd;
  logic [UNROLL-1:0][31:0] w_beat;
  hash_t  chain [UNROLL+1];

`ifdef SHA2_SCHEDULE_EN
  // win[i] holds W[rnd+i]; UNROLL fresh words are appended per ROUND cycle.
  logic [15:0][31:0] win;
  logic [UNROLL-1:0][31:0] w_new;

  function automatic logic [UNROLL-1:0][31:0] expand(input logic [15:0][31:0] cw);
    logic [16+UNROLL-1:0][31:0] ext;
    ext = '0;
    ext[15:0] = cw;
    for (int j = 0; j < UNROLL; j++)
      ext[16+j] = small_sigma1(ext[14+j]) + ext[9+j] + small_sigma0(ext[1+j]) + ext[j];
    return ext[16+UNROLL-1:16];
  endfunction

  assign w_new  = expand(win);
  assign w_beat = win[UNROLL-1:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      win <= '0;
    end else if (accept) begin
      for (int i = 0; i < 16; i++) win[i] <= blk_i[511-32*i -: 32];
    end else if (beat) begin
      win <= {w_new, win[15:UNROLL]};
    end
  end
`else
  assign w_beat = w_i;
`endif

  assign chain[0] = wk;

  for (genvar j = 0; j < UNROLL; j++) begin : g_rnd
    sha2_round u_round (
      .cur (chain[j]),
      .k   (K[rnd + 6'(j)]),
      .w   (w_beat[j]),
      .nxt (chain[j+1])
    );
  end

  always_comb begin
    h_sum = '0;
    for (int i = 0; i < 8; i++) h_sum[i] = h_q[i] + wk[i];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    blk_ready_o = (state == IDLE);
    busy_o      = (state != IDLE);
    done_o      = done_q;
    digest_o    = digest_q;
`ifdef SHA2_SCHEDULE_EN
    beat        = (state == ROUND);
`else
    w_ready_o   = (state == ROUND);
    beat        = w_valid_i & (state == ROUND);
`endif
    if (abort_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:  if (blk_valid_i) begin
                 accept    = 1'b1;
                 state_nxt = LOAD;
               end
        LOAD:  state_nxt = ROUND;
        ROUND: if (beat && rnd == 6'(LAST)) state_nxt = FINAL;
        FINAL: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_q      <= IV256;
      wk       <= '0;
      digest_q <= IV256;
      mode_q   <= 1'b0;
      done_q   <= 1'b0;
      rnd      <= '0;
    end else begin
      done_q <= 1'b0;
      if (abort_i) begin
        rnd <= '0;
      end else begin
        case (state)
          IDLE: if (accept && init_i) begin
                  mode_q <= mode_i;
                  h_q    <= mode_i ? IV224 : IV256;
                end
          LOAD: begin
                  wk  <= h_q;
                  rnd <= '0;
                end
          // rnd wraps to 0 on the last beat
          ROUND: if (beat) begin
                   wk  <= chain[UNROLL];
                   rnd <= rnd + 6'(UNROLL);
                 end
          FINAL: begin
                   h_q      <= h_sum;
                   digest_q <= mode_q ? {h_sum[7:1], 32'h0} : h_sum;
                   done_q   <= 1'b1;
                 end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sha2_round_engine.sv
// Self-checking bench for sha2_round_engine (external W build) against a plain SHA-2 model.
module tb_sha2_round_engine;

  localparam int UNROLL = 1;
  localparam int N      = 64 / UNROLL;

  localparam logic [255:0] IV256  = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] IV224  = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
  localparam logic [255:0] ABC256 = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] ABC224 = 256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;
  localparam logic [255:0] TWO256 = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  localparam logic [31:0] TK [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic clk = 1'b0;
  logic rst, abort, blk_valid, init, mode, w_valid;
  logic [32*UNROLL-1:0] w;
  logic blk_ready, w_ready, done, busy;
  logic [255:0] digest;

  int ncmp = 0;
  int nfail = 0;
  int done_cnt = 0;
  int blocks = 0;

  logic [255:0] mh;
  logic         mmode;
  logic [31:0]  ws [64];

  always #5 clk = ~clk;

  sha2_round_engine #(.UNROLL(UNROLL)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .abort_i     (abort),
    .blk_valid_i (blk_valid),
    .blk_ready_o (blk_ready),
    .init_i      (init),
    .mode_i      (mode),
    .w_valid_i   (w_valid),
    .w_ready_o   (w_ready),
    .w_i         (w),
    .done_o      (done),
    .digest_o    (digest),
    .busy_o      (busy)
  );

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic expand(input logic [511:0] b);
    for (int t = 0; t < 16; t++) ws[t] = b[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      ws[t] = (rotr(ws[t-2], 17) ^ rotr(ws[t-2], 19) ^ (ws[t-2] >> 10)) + ws[t-7]
            + (rotr(ws[t-15], 7) ^ rotr(ws[t-15], 18) ^ (ws[t-15] >> 3)) + ws[t-16];
  endtask

  function automatic logic [255:0] compress(input logic [255:0] hin);
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    logic [255:0] v, r;
    {a, b, c, d, e, f, g, hh} = hin;
    for (int t = 0; t < 64; t++) begin
      t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + TK[t] + ws[t];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    v = {a, b, c, d, e, f, g, hh};
    for (int i = 0; i < 8; i++) r[32*i +: 32] = hin[32*i +: 32] + v[32*i +: 32];
    return r;
  endfunction

  task automatic load_words(input int idx);
    for (int j = 0; j < UNROLL; j++) w[32*j +: 32] = (idx + j < 64) ? ws[idx + j] : 32'h0;
  endtask

  // Accepts one block, feeds W with random gaps, returns in the done_o cycle.
  task automatic run_block(input string tag, input logic [511:0] b, input logic in_init,
                           input logic in_mode, input int gap_pct);
    int idx, lat;
    logic rdy, got;
    logic [255:0] exp;
    expand(b);
    if (in_init) begin
      mmode = in_mode;
      mh    = in_mode ? IV224 : IV256;
    end
    mh  = compress(mh);
    exp = mmode ? {mh[255:32], 32'h0} : mh;
    blocks++;
    blk_valid = 1'b1; init = in_init; mode = in_mode;
    @(posedge clk); #1;
    blk_valid = 1'b0; init = 1'($urandom); mode = 1'($urandom);
    idx = 0; lat = 0; got = 1'b0;
    while (!got && lat < 2000) begin
      rdy     = w_ready;
      w_valid = (idx < 64) && (int'($urandom_range(99)) >= gap_pct);
      load_words(idx);
      @(posedge clk); #1;
      lat++;
      if (w_valid && rdy) idx += UNROLL;
      if (done) got = 1'b1;
    end
    w_valid = 1'b0;
    check({tag, "_done_seen"}, 256'(got), 256'(1));
    if (gap_pct == 0) check({tag, "_latency"}, 256'(lat), 256'(N + 2));
    check({tag, "_words_used"}, 256'(idx), 256'(64));
    check({tag, "_digest"}, digest, exp);
    check({tag, "_ready_in_done"}, 256'(blk_ready), 256'(1));
  endtask

  // Starts a chained block and stops after a given number of W beats.
  task automatic partial(input logic [511:0] b, input int beats);
    int idx, lim;
    logic rdy;
    expand(b);
    blk_valid = 1'b1; init = 1'b0; mode = 1'b0;
    @(posedge clk); #1;
    blk_valid = 1'b0;
    idx = 0; lim = 0;
    while (idx < beats && lim < 200) begin
      rdy = w_ready; w_valid = 1'b1;
      load_words(idx);
      @(posedge clk); #1;
      lim++;
      if (rdy) idx += UNROLL;
    end
    w_valid = 1'b0;
    check("partial_beats", 256'(idx), 256'(beats));
  endtask

  initial begin
    logic [511:0] abc, two1, two2, rb;
    logic [255:0] dsave;
    abc  = {"abc", 8'h80, 416'h0, 64'h18};
    two1 = {"abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", 32'h80000000, 32'h0};
    two2 = {448'h0, 64'h1c0};
    rst = 1'b1; abort = 1'b0; blk_valid = 1'b0; init = 1'b0; mode = 1'b0;
    w_valid = 1'b0; w = '0;
    mh = IV256; mmode = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    check("rst_blk_ready", 256'(blk_ready), 256'(1));
    check("rst_w_ready", 256'(w_ready), 256'(0));
    check("rst_done", 256'(done), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_digest", digest, IV256);

    run_block("abc256", abc, 1'b1, 1'b0, 0);
    check("abc256_known", digest, ABC256);
    @(posedge clk); #1;
    check("done_single_pulse", 256'(done), 256'(0));

    run_block("abc224", abc, 1'b1, 1'b1, 0);
    check("abc224_known", digest, ABC224);
    @(posedge clk); #1;

    // second block accepted in the done_o cycle of the first
    run_block("two_b1", two1, 1'b1, 1'b0, 0);
    run_block("two_b2", two2, 1'b0, 1'b1, 0);
    check("two_known", digest, TWO256);
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 16; k++) rb[32*k +: 32] = $urandom;
      run_block("rand", rb, (i == 0 || i == 2), 1'($urandom), 50);
    end
    @(posedge clk); #1;

    dsave = digest;
    for (int k = 0; k < 16; k++) rb[32*k +: 32] = $urandom;
    partial(rb, 30);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_ready", 256'(blk_ready), 256'(1));
    check("abort_busy", 256'(busy), 256'(0));
    check("abort_done", 256'(done), 256'(0));
    check("abort_digest", digest, dsave);
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_done", 256'(done_cnt), 256'(blocks));
    for (int k = 0; k < 16; k++) rb[32*k +: 32] = $urandom;
    run_block("after_abort", rb, 1'b0, 1'b0, 0);
    @(posedge clk); #1;

    for (int k = 0; k < 16; k++) rb[32*k +: 32] = $urandom;
    partial(rb, 20);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check("midrst_ready", 256'(blk_ready), 256'(1));
    check("midrst_w_ready", 256'(w_ready), 256'(0));
    check("midrst_busy", 256'(busy), 256'(0));
    check("midrst_digest", digest, IV256);
    mh = IV256; mmode = 1'b0;
    @(posedge clk); #1;
    check("midrst_done", 256'(done), 256'(0));
    run_block("chain_after_rst", abc, 1'b0, 1'b1, 0);
    check("chain_after_rst_known", digest, ABC256);
    @(posedge clk); #1;

    check("done_count", 256'(done_cnt), 256'(blocks));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
